// File: rtl/controle_es_atraso.sv
// Executes the delay / switch-input / display-output instructions of the ctrl4 bundle
// and stalls the fetch logic while a delay or an input is pending.
module controle_es_atraso #(
    parameter int DATA_W   = 32,
    parameter int CHAVE_W  = 16,
    parameter int CONT_W   = 16,
    parameter int TICK_DIV = 50000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              delay,
    input  logic              entrada,
    input  logic              saida,
    input  logic [DATA_W-1:0] dado_reg,
    input  logic [CHAVE_W-1:0] chave,
    input  logic              botao_ok,
    output logic              parado,
    output logic              esc_entrada,
    output logic [DATA_W-1:0] dado_entrada,
    output logic [DATA_W-1:0] saida_display,
    output logic              saida_valida,
    output logic [1:0]        estado
);

    localparam logic [1:0] OCIOSO  = 2'd0;
    localparam logic [1:0] ATRASO  = 2'd1;
    localparam logic [1:0] ESPERA  = 2'd2;
    localparam logic [1:0] CONCLUI = 2'd3;

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

    logic [CHAVE_W-1:0] chave_m, chave_s;
    logic               botao_m, botao_s, botao_ant;
    logic               btn_borda;
    logic [CONT_W-1:0]  rest;
    logic [PRE_W-1:0]   pre;
    logic [CONT_W-1:0]  n;

    assign n         = dado_reg[CONT_W-1:0];
    // Only a fresh press counts, so a button held before the input instruction is ignored.
    assign btn_borda = botao_s & ~botao_ant;

    always_comb begin
        parado = 1'b0;
        if (estado == OCIOSO)
            parado = delay | entrada;
        else if (estado == ATRASO || estado == ESPERA)
            parado = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado        <= OCIOSO;
            chave_m       <= '0;
            chave_s       <= '0;
            botao_m       <= 1'b0;
            botao_s       <= 1'b0;
            botao_ant     <= 1'b0;
            rest          <= '0;
            pre           <= '0;
            esc_entrada   <= 1'b0;
            dado_entrada  <= '0;
            saida_display <= '0;
            saida_valida  <= 1'b0;
        end else begin
            chave_m      <= chave;
            chave_s      <= chave_m;
            botao_m      <= botao_ok;
            botao_s      <= botao_m;
            botao_ant    <= botao_s;
            esc_entrada  <= 1'b0;
            saida_valida <= 1'b0;
            case (estado)
                OCIOSO: begin
                    if (entrada) begin
                        estado <= ESPERA;
                    end else if (delay) begin
                        if (n == '0) begin
                            estado <= CONCLUI;
                        end else begin
                            rest   <= n;
                            pre    <= PRE_MAX;
                            estado <= ATRASO;
                        end
                    end else if (saida) begin
                        saida_display <= dado_reg;
                        saida_valida  <= 1'b1;
                    end
                end
                ATRASO: begin
                    // Each delay unit is TICK_DIV cycles; the last unit exits straight to CONCLUI.
                    if (pre == '0) begin
                        pre <= PRE_MAX;
                        if (rest == CONT_W'(1))
                            estado <= CONCLUI;
                        else
                            rest <= rest - CONT_W'(1);
                    end else begin
                        pre <= pre - PRE_W'(1);
                    end
                end
                ESPERA: begin
                    if (btn_borda) begin
                        dado_entrada <= DATA_W'(chave_s);
                        esc_entrada  <= 1'b1;
                        estado       <= CONCLUI;
                    end
                end
                default: begin
                    // CONCLUI ignores ctrl4 so the retiring instruction cannot re-trigger.
                    estado <= OCIOSO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_controle_es_atraso.sv
// Bench for controle_es_atraso with TICK_DIV=4: delays, switch input, display output and resets.
module tb_controle_es_atraso;

    localparam int DATA_W = 32;
    localparam int CHAVE_W = 16;
    localparam int TICK_DIV = 4;
    localparam logic [1:0] S_OCIOSO = 2'd0;
    localparam logic [1:0] S_ESPERA = 2'd2;
    localparam logic [1:0] S_CONCLUI = 2'd3;

    logic              clock = 1'b0;
    logic              reset, delay, entrada, saida, botao_ok;
    logic [DATA_W-1:0] dado_reg;
    logic [CHAVE_W-1:0] chave;
    logic              parado, esc_entrada, saida_valida;
    logic [DATA_W-1:0] dado_entrada, saida_display;
    logic [1:0]        estado;

    int n_cmp = 0;
    int n_err = 0;
    int in_pulses = 0;
    int disp_pulses = 0;
    logic [DATA_W-1:0] exp_disp_q[$];
    logic [DATA_W-1:0] exp_in_q[$];

    controle_es_atraso #(.DATA_W(DATA_W), .CHAVE_W(CHAVE_W), .CONT_W(16), .TICK_DIV(TICK_DIV)) dut (
        .clock(clock), .reset(reset), .delay(delay), .entrada(entrada), .saida(saida),
        .dado_reg(dado_reg), .chave(chave), .botao_ok(botao_ok), .parado(parado),
        .esc_entrada(esc_entrada), .dado_entrada(dado_entrada), .saida_display(saida_display),
        .saida_valida(saida_valida), .estado(estado)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every output pulse must consume one expected value.
    always @(negedge clock) begin
        if (saida_valida === 1'b1) begin
            disp_pulses++;
            check("disp_expected", 32'(exp_disp_q.size() != 0), 32'd1);
            if (exp_disp_q.size() != 0) check("saida_display", saida_display, exp_disp_q.pop_front());
        end
        if (esc_entrada === 1'b1) begin
            in_pulses++;
            check("in_expected", 32'(exp_in_q.size() != 0), 32'd1);
            check("esc_parado", 32'(parado), 32'd0);
            if (exp_in_q.size() != 0) check("dado_entrada", dado_entrada, exp_in_q.pop_front());
        end
    end

    task automatic tick(input int k);
        repeat (k) @(posedge clock);
        #1;
    endtask

    task automatic run_delay(input logic [DATA_W-1:0] units, input int exp_len);
        int cnt;
        bit done;
        tick(1);
        delay = 1'b1;
        dado_reg = units;
        cnt = 0;
        done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clock);
            if (parado) cnt++;
            else done = 1;
        end
        check("delay_done", 32'(done), 32'd1);
        check("delay_len", 32'(cnt), 32'(exp_len));
        check("delay_conclui", 32'(estado), 32'(S_CONCLUI));
        delay = 1'b0;
        @(negedge clock);
        check("delay_no_retrigger", 32'(parado), 32'd0);
        check("delay_idle", 32'(estado), 32'(S_OCIOSO));
    endtask

    task automatic press_button;
        botao_ok = 1'b0;
        tick(4);
        botao_ok = 1'b1;
    endtask

    initial begin
        bit got;
        logic [CHAVE_W-1:0] sw;
        logic [DATA_W-1:0] v;
        reset = 1'b1; delay = 0; entrada = 0; saida = 0; botao_ok = 0;
        dado_reg = '0; chave = '0;
        tick(3);
        reset = 1'b0;
        @(negedge clock);
        check("rst_state", 32'(estado), 32'(S_OCIOSO));
        check("rst_parado", 32'(parado), 32'd0);
        check("rst_esc", 32'(esc_entrada), 32'd0);
        check("rst_valida", 32'(saida_valida), 32'd0);
        check("rst_disp", saida_display, 32'd0);
        check("rst_din", dado_entrada, 32'd0);

        // Back-to-back output instructions, then a random one.
        tick(1);
        saida = 1'b1; dado_reg = 32'd7; exp_disp_q.push_back(32'd7);
        @(negedge clock);
        check("saida_parado0", 32'(parado), 32'd0);
        tick(1);
        dado_reg = 32'd9; exp_disp_q.push_back(32'd9);
        @(negedge clock);
        check("saida_parado1", 32'(parado), 32'd0);
        tick(1);
        v = $urandom;
        dado_reg = v; exp_disp_q.push_back(v);
        tick(1);
        saida = 1'b0;
        tick(2);
        check("disp_last", saida_display, v);

        // Reset in the middle of a delay.
        delay = 1'b1; dado_reg = 32'd5;
        tick(6);
        reset = 1'b1;
        tick(3);
        reset = 1'b0; delay = 1'b0;
        @(negedge clock);
        check("rstmid_state", 32'(estado), 32'(S_OCIOSO));
        check("rstmid_parado", 32'(parado), 32'd0);
        check("rstmid_disp", saida_display, 32'd0);
        check("rstmid_valida", 32'(saida_valida), 32'd0);

        run_delay(32'd3, 1 + 3 * TICK_DIV);
        run_delay(32'd0, 1);
        run_delay(32'h0001_0001, 1 + 1 * TICK_DIV);

        // Input with the button already held on entry.
        botao_ok = 1'b1;
        tick(5);
        entrada = 1'b1;
        tick(10);
        check("held_state", 32'(estado), 32'(S_ESPERA));
        check("held_parado", 32'(parado), 32'd1);
        check("held_no_pulse", 32'(in_pulses), 32'd0);
        chave = 16'hA5A5;
        exp_in_q.push_back(32'h0000_A5A5);
        press_button();
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clock);
            if (esc_entrada) got = 1;
        end
        check("in_seen", 32'(got), 32'd1);
        check("in_conclui", 32'(estado), 32'(S_CONCLUI));
        entrada = 1'b0;
        @(negedge clock);
        check("in_single_pulse", 32'(esc_entrada), 32'd0);
        check("in_idle", 32'(estado), 32'(S_OCIOSO));

        // A random switch word on a second input instruction.
        sw = 16'($urandom);
        botao_ok = 1'b0;
        tick(3);
        entrada = 1'b1; chave = sw;
        exp_in_q.push_back(32'(sw));
        tick(2);
        press_button();
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clock);
            if (esc_entrada) got = 1;
        end
        check("in2_seen", 32'(got), 32'd1);
        entrada = 1'b0;
        tick(2);

        // Reset while waiting for the button: nothing may be captured.
        botao_ok = 1'b0;
        entrada = 1'b1;
        tick(4);
        check("esp_state", 32'(estado), 32'(S_ESPERA));
        chave = 16'h1234;
        reset = 1'b1;
        tick(2);
        reset = 1'b0; entrada = 1'b0;
        press_button();
        tick(10);
        check("rstesp_din", dado_entrada, 32'd0);
        check("rstesp_state", 32'(estado), 32'(S_OCIOSO));

        check("in_pulse_count", 32'(in_pulses), 32'd2);
        check("disp_pulse_count", 32'(disp_pulses), 32'd3);
        check("disp_q_empty", 32'(exp_disp_q.size()), 32'd0);
        check("in_q_empty", 32'(exp_in_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
